// File: rtl/mmio_bus_fabric_if.sv
// CPU data port and peripheral bus bundled into one interface.
// The fabric takes the slave view; the CPU/peripheral environment takes the master view.
interface mmio_bus_fabric_if #(
  parameter int unsigned N          = 32,
  parameter int unsigned NUM_SLAVES = 3
) ();
  logic                    m_req;
  logic                    m_we;
  logic [N-1:0]            m_addr;
  logic [N-1:0]            m_wdata;
  logic                    m_ready;
  logic [N-1:0]            m_rdata;
  logic                    m_err;
  logic [NUM_SLAVES-1:0]   s_sel;
  logic                    s_we;
  logic [N-1:0]            s_addr;
  logic [N-1:0]            s_wdata;
  logic [NUM_SLAVES*N-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]   s_ack;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
    output m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
    input  m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmio_bus_fabric.sv
// Registered MMIO interconnect: decodes CPU requests onto NUM_SLAVES address windows,
// waits for the slave ack (with optional timeout) and returns a single response strobe.
module mmio_bus_fabric #(
  parameter int unsigned             N          = 32,
  parameter int unsigned             NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*N-1:0] BASE       = {32'h4004, 32'h4000, 32'h0000},
  parameter logic [NUM_SLAVES*N-1:0] LIMIT      = {32'h40FF, 32'h4003, 32'h3FFF},
  parameter int unsigned             TIMEOUT    = 16,
  parameter int unsigned             ERRW       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mmio_bus_fabric_if.slave       bus,
  output logic [ERRW-1:0]        err_count
);

  localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q;
  logic                  m_ready_q;
  logic [N-1:0]          m_rdata_q;
  logic                  m_err_q;
  logic [NUM_SLAVES-1:0] s_sel_q;
  logic                  s_we_q;
  logic [N-1:0]          s_addr_q;
  logic [N-1:0]          s_wdata_q;
  logic [IW-1:0]         sel_idx_q;
  logic [CW-1:0]         cnt_q;
  logic [ERRW-1:0]       err_count_q;

  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic [N-1:0]          hit_off;

  // Scan from the top index down so the lowest matching window wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((bus.m_addr >= BASE[i*N +: N]) && (bus.m_addr <= LIMIT[i*N +: N])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
        hit_off = bus.m_addr - BASE[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      m_ready_q   <= 1'b0;
      m_rdata_q   <= '0;
      m_err_q     <= 1'b0;
      s_sel_q     <= '0;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      sel_idx_q   <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.m_req) begin
            if (hit) begin
              state_q   <= StAccess;
              s_sel_q   <= NUM_SLAVES'(1) << hit_idx;
              s_we_q    <= bus.m_we;
              s_addr_q  <= hit_off;
              s_wdata_q <= bus.m_we ? bus.m_wdata : '0;
              sel_idx_q <= hit_idx;
              cnt_q     <= '0;
            end else begin
              state_q   <= StResp;
              m_ready_q <= 1'b1;
              m_err_q   <= 1'b1;
              m_rdata_q <= '0;
              if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            end
          end
        end
        StAccess: begin
          if (bus.s_ack[sel_idx_q]) begin
            state_q   <= StResp;
            m_ready_q <= 1'b1;
            m_err_q   <= 1'b0;
            m_rdata_q <= s_we_q ? '0 : bus.s_rdata[sel_idx_q*N +: N];
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            cnt_q     <= '0;
          end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
            state_q   <= StResp;
            m_ready_q <= 1'b1;
            m_err_q   <= 1'b1;
            m_rdata_q <= '0;
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            cnt_q     <= '0;
            if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          m_ready_q <= 1'b0;
          m_err_q   <= 1'b0;
          cnt_q     <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_ready = m_ready_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_err   = m_err_q;
  assign bus.s_sel   = s_sel_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign err_count   = err_count_q;

endmodule
